data_tile_fetch: RTL and testbench
==================================

DATA_TILE_FETCH -- requirements
Module: data_tile_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width per port.
REQ-002 SHALL have parameter DATA_W, default 512, width of one feature-map row (one memory word).
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse, begins a feature-map pass.
REQ-006 SHALL have port base_addr  input  ADDR_W  address of row 0, sampled on accepted start.
REQ-007 SHALL have port num_rows  input  ADDR_W  feature-map height in rows, sampled on accepted start.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at end of pass.
REQ-010 SHALL have port err  output  1  high with done when num_rows is illegal; held until next accepted start.
REQ-011 SHALL have ports addr_1_out, addr_2_out  output  ADDR_W  read addresses to memory ports 1/2.
REQ-012 SHALL have ports addr_1_valid_out, addr_2_valid_out  output  1  read-request strobes.
REQ-013 SHALL have ports data_1_in, data_2_in  input  DATA_W  returned row data.
REQ-014 SHALL have ports data_1_valid_in, data_2_valid_in  input  1  returned-data strobes.
REQ-015 SHALL have port tile_out  output  4*DATA_W  four rows; row k at bits [k*DATA_W +: DATA_W].
REQ-016 SHALL have port tile_row_idx  output  ADDR_W  feature-map row index of tile row 0.
REQ-017 SHALL have ports tile_valid_out  output  1  and tile_ready_in  input  1  valid/ready tile handshake.

Function
REQ-018 SHALL implement states IDLE, FETCH_LO, FETCH_HI, WAIT, PRESENT, FINISH.
REQ-019 In IDLE, start SHALL be accepted; start in any other state SHALL be ignored.
REQ-020 Legal num_rows SHALL be even and >=4; otherwise IDLE->FINISH with err=1 and no memory request issued.
REQ-021 Tile count SHALL be (num_rows-2)/2; tile t covers rows 2t..2t+3 (stride 2, Winograd F(2x2,3x3)).
REQ-022 First tile: FETCH_LO SHALL issue rows 0,1 (port1,port2) with both valids high for one cycle; next cycle FETCH_HI SHALL issue rows 2,3.
REQ-023 Subsequent tiles SHALL shift held rows 2,3 into slots 0,1 on handshake and fetch only the two new rows via FETCH_HI.
REQ-024 Address SHALL be base_addr + row, modulo 2^ADDR_W (wraps, no error).
REQ-025 Memory returns data one cycle after request; returned pairs SHALL be captured in issue order (first pair -> slots 0,1, second -> 2,3; reuse tile: only pair -> 2,3).
REQ-026 A port's data SHALL be captured only when its own valid_in is high and a response is outstanding; unexpected valids SHALL be ignored.
REQ-027 WAIT SHALL exit to PRESENT only when all outstanding rows of both ports have been captured.
REQ-028 In PRESENT, tile_valid_out SHALL be high and tile_out, tile_row_idx stable until tile_ready_in high at a clock edge.
REQ-029 On handshake: last tile -> FINISH; else -> FETCH_HI for next tile (no prefetch before handshake).
REQ-030 FINISH SHALL pulse done for one cycle, clear busy, return to IDLE.
REQ-031 Addr valids SHALL be low outside FETCH_LO/FETCH_HI; addr outputs SHALL hold last value when valids low.
REQ-032 Minimum first-tile latency from accepted start to tile_valid_out SHALL be 4 cycles (start edge, LO, HI, WAIT).

Reset
REQ-033 On reset assertion, state SHALL go to IDLE immediately, mid-operation included; outstanding responses discarded.
REQ-034 Reset values: busy, done, err, all addr valids, tile_valid_out = 0; addr outputs, tile_row_idx, tile_out = 0.
REQ-035 After reset deassertion, no request SHALL issue until a new start.

Verification
REQ-036 base_addr=0x10, num_rows=6, ready always high -> requests 0x10/0x11, 0x12/0x13, then 0x14/0x15; 2 tiles, tile_row_idx 0,2; done pulse; err=0.
REQ-037 num_rows=5, and separately num_rows=2 -> done and err=1 one cycle after FINISH entry, no addr valid ever asserted.
REQ-038 base_addr=0xFE, num_rows=4 -> addresses 0xFE,0xFF,0x00,0x01; tile rows match memory contents at those addresses.
REQ-039 tile_ready_in held low 10 cycles in PRESENT -> tile_out/tile_valid_out stable, no new requests; start pulses during pass ignored.
REQ-040 Reset asserted in WAIT with data valids arriving next cycle -> all outputs 0, state IDLE, late data not captured, busy stays 0.
REQ-041 Spurious data_2_valid_in in IDLE and PRESENT -> tile_out unchanged.

Source files
------------

// File: rtl/data_tile_fetch.sv
// Row fetcher that assembles 4-row, stride-2 feature-map tiles from two memory read ports
// and presents each tile through a valid/ready handshake.
module data_tile_fetch #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   num_rows,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   addr_1_out,
  output logic [ADDR_W-1:0]   addr_2_out,
  output logic                addr_1_valid_out,
  output logic                addr_2_valid_out,
  input  logic [DATA_W-1:0]   data_1_in,
  input  logic [DATA_W-1:0]   data_2_in,
  input  logic                data_1_valid_in,
  input  logic                data_2_valid_in,
  output logic [4*DATA_W-1:0] tile_out,
  output logic [ADDR_W-1:0]   tile_row_idx,
  output logic                tile_valid_out,
  input  logic                tile_ready_in
);

  localparam int unsigned AW1 = ADDR_W + 1;

  typedef enum logic [2:0] {
    StIdle, StFetchLo, StFetchHi, StWait, StPresent, StFinish
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, rows_q, row_q;
  logic [ADDR_W-1:0]   addr_1_q, addr_2_q;
  logic [DATA_W-1:0]   slot_q [4];
  logic [1:0]          lo_q, lo_d, hi_q, hi_d, cap;
  logic                busy_q, done_q, err_q;
  logic                legal_in, rows_bad_q, last_tile, handshake, accept;

  assign legal_in   = !num_rows[0] && (num_rows >= ADDR_W'(4));
  assign rows_bad_q = rows_q[0] || (rows_q < ADDR_W'(4));
  assign last_tile  = ({1'b0, row_q} + AW1'(4)) >= {1'b0, rows_q};
  assign handshake  = (state_q == StPresent) && tile_ready_in;
  assign accept     = (state_q == StIdle) && start;

  // Per port, lo/hi flag an outstanding response for the low (0/1) or high (2/3) slot pair.
  // Responses return in issue order, so a pending low request is always the oldest.
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    cap  = {data_2_valid_in, data_1_valid_in} & (lo_q | hi_q);
    for (int p = 0; p < 2; p++) begin
      if (cap[p]) begin
        if (lo_q[p]) lo_d[p] = 1'b0;
        else         hi_d[p] = 1'b0;
      end
    end
    if (state_q == StFetchLo) lo_d = 2'b11;
    if (state_q == StFetchHi) hi_d = 2'b11;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = legal_in ? StFetchLo : StFinish;
      StFetchLo: state_d = StFetchHi;
      StFetchHi: state_d = StWait;
      StWait:    if (~|{lo_d, hi_d}) state_d = StPresent;
      StPresent: if (tile_ready_in) state_d = last_tile ? StFinish : StFetchHi;
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      base_q   <= '0;
      rows_q   <= '0;
      row_q    <= '0;
      addr_1_q <= '0;
      addr_2_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int k = 0; k < 4; k++) slot_q[k] <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= (state_q == StFinish);
      if (accept) begin
        base_q <= base_addr;
        rows_q <= num_rows;
        row_q  <= '0;
        busy_q <= 1'b1;
        err_q  <= 1'b0;
        if (legal_in) begin
          addr_1_q <= base_addr;
          addr_2_q <= base_addr + ADDR_W'(1);
        end
      end
      if (state_q == StFetchLo) begin
        addr_1_q <= base_q + row_q + ADDR_W'(2);
        addr_2_q <= base_q + row_q + ADDR_W'(3);
      end
      if (state_q == StFinish) begin
        busy_q <= 1'b0;
        err_q  <= rows_bad_q;
      end
      // Next tile reuses rows 2,3 of the current one as its rows 0,1.
      if (handshake && !last_tile) begin
        row_q     <= row_q + ADDR_W'(2);
        addr_1_q  <= base_q + row_q + ADDR_W'(4);
        addr_2_q  <= base_q + row_q + ADDR_W'(5);
        slot_q[0] <= slot_q[2];
        slot_q[1] <= slot_q[3];
      end
      if (cap[0]) slot_q[lo_q[0] ? 0 : 2] <= data_1_in;
      if (cap[1]) slot_q[lo_q[1] ? 1 : 3] <= data_2_in;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign addr_1_out       = addr_1_q;
  assign addr_2_out       = addr_2_q;
  assign addr_1_valid_out = (state_q == StFetchLo) || (state_q == StFetchHi);
  assign addr_2_valid_out = addr_1_valid_out;
  assign tile_out         = {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
  assign tile_row_idx     = row_q;
  assign tile_valid_out   = (state_q == StPresent);

endmodule

// File: tb/tb_data_tile_fetch.sv
// Directed bench for data_tile_fetch: vector table of passes plus stall, spurious-data and
// mid-pass reset sequences against a one-cycle-latency memory model.
module tb_data_tile_fetch;
  localparam int AW = 8;
  localparam int DW = 512;

  logic            clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [AW-1:0]   base_addr = '0, num_rows = '0;
  logic            busy, done, err;
  logic [AW-1:0]   addr_1_out, addr_2_out, tile_row_idx;
  logic            addr_1_valid_out, addr_2_valid_out, tile_valid_out;
  logic [DW-1:0]   data_1_in, data_2_in;
  logic            data_1_valid_in, data_2_valid_in;
  logic [4*DW-1:0] tile_out;
  logic            tile_ready_in = 1'b1;

  logic            mem_v1 = 1'b0, mem_v2 = 1'b0, spur_v2 = 1'b0;
  logic [DW-1:0]   mem_d1 = '0, mem_d2 = '0;
  logic [AW-1:0]   q1[$], q2[$];

  int total = 0;
  int bad   = 0;

  data_tile_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .err(err),
    .addr_1_out(addr_1_out), .addr_2_out(addr_2_out),
    .addr_1_valid_out(addr_1_valid_out), .addr_2_valid_out(addr_2_valid_out),
    .data_1_in(data_1_in), .data_2_in(data_2_in),
    .data_1_valid_in(data_1_valid_in), .data_2_valid_in(data_2_valid_in),
    .tile_out(tile_out), .tile_row_idx(tile_row_idx),
    .tile_valid_out(tile_valid_out), .tile_ready_in(tile_ready_in)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    word = {(DW/8){a}} ^ {(DW/32){32'h9e37_79b9}};
  endfunction

  // Memory model: one-cycle read latency, independent of DUT reset.
  always @(posedge clk) begin
    mem_v1 <= addr_1_valid_out;
    mem_v2 <= addr_2_valid_out;
    mem_d1 <= word(addr_1_out);
    mem_d2 <= word(addr_2_out);
  end
  assign data_1_valid_in = mem_v1;
  assign data_1_in       = mem_d1;
  assign data_2_valid_in = mem_v2 | spur_v2;
  assign data_2_in       = spur_v2 ? '1 : mem_d2;

  always @(negedge clk) begin
    if (addr_1_valid_out) q1.push_back(addr_1_out);
    if (addr_2_valid_out) q2.push_back(addr_2_out);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " err"}, 64'(err), 64'd0);
    chk({tag, " avalid"}, 64'({addr_1_valid_out, addr_2_valid_out}), 64'd0);
    chk({tag, " addr"}, 64'({addr_1_out, addr_2_out}), 64'd0);
    chk({tag, " tvalid"}, 64'(tile_valid_out), 64'd0);
    chk({tag, " tidx"}, 64'(tile_row_idx), 64'd0);
    chk({tag, " tile_zero"}, 64'(tile_out == '0), 64'd1);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] rows;
    logic          exp_err;
    int            exp_tiles;
    int            exp_nreq;
  } vec_t;

  task automatic run_pass(input vec_t v);
    int       cyc, tiles, first_lat;
    bit       got_done;
    logic [AW-1:0] a;
    q1.delete();
    q2.delete();
    tile_ready_in = 1'b1;
    @(negedge clk);
    base_addr = v.base;
    num_rows  = v.rows;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("err_cleared", 64'(err), 64'd0);
    cyc = 1; tiles = 0; got_done = 0; first_lat = 0;
    while (!got_done && cyc < 300) begin
      if (tile_valid_out) begin
        if (tiles == 0) first_lat = cyc;
        chk("tile_row_idx", 64'(tile_row_idx), 64'(2 * tiles));
        for (int k = 0; k < 4; k++) begin
          a = v.base + AW'(2 * tiles + k);
          chk_w($sformatf("tile%0d_row%0d", tiles, k), tile_out[k*DW +: DW], word(a));
        end
        tiles++;
      end
      if (done) begin
        got_done = 1;
        chk("busy_at_done", 64'(busy), 64'd0);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", 64'(got_done), 64'd1);
    chk("err_at_done", 64'(err), 64'(v.exp_err));
    chk("tile_count", 64'(tiles), 64'(v.exp_tiles));
    chk("req_count_1", 64'(q1.size()), 64'(v.exp_nreq));
    chk("req_count_2", 64'(q2.size()), 64'(v.exp_nreq));
    for (int j = 0; j < q1.size() && j < v.exp_nreq; j++) begin
      chk($sformatf("req%0d_addr1", j), 64'(q1[j]), 64'(AW'(v.base + AW'(2 * j))));
      chk($sformatf("req%0d_addr2", j), 64'(q2[j]), 64'(AW'(v.base + AW'(2 * j + 1))));
    end
    if (v.exp_err) chk("err_done_latency", 64'(cyc), 64'd2);
    else begin
      chk("first_tile_latency", 64'(first_lat), 64'd4);
      chk("addr1_held", 64'(addr_1_out), 64'(AW'(v.base + AW'(2 * (v.exp_nreq - 1)))));
    end
    @(negedge clk);
    chk("done_pulse_ends", 64'(done), 64'd0);
    chk("err_held", 64'(err), 64'(v.exp_err));
  endtask

  vec_t vecs[7];

  initial begin
    logic [4*DW-1:0] snap;
    int n1, cyc;

    vecs[0] = '{base: 8'h10, rows: 8'd6,  exp_err: 1'b0, exp_tiles: 2, exp_nreq: 3};
    vecs[1] = '{base: 8'h00, rows: 8'd5,  exp_err: 1'b1, exp_tiles: 0, exp_nreq: 0};
    vecs[2] = '{base: 8'h00, rows: 8'd2,  exp_err: 1'b1, exp_tiles: 0, exp_nreq: 0};
    vecs[3] = '{base: 8'hFE, rows: 8'd4,  exp_err: 1'b0, exp_tiles: 1, exp_nreq: 2};
    vecs[4] = '{base: 8'h40, rows: 8'd10, exp_err: 1'b0, exp_tiles: 4, exp_nreq: 5};
    vecs[5] = '{base: 8'h20, rows: 8'd0,  exp_err: 1'b1, exp_tiles: 0, exp_nreq: 0};
    vecs[6] = '{base: 8'hFA, rows: 8'd8,  exp_err: 1'b0, exp_tiles: 3, exp_nreq: 4};

    #2;
    chk_zero_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("no_req_after_reset", 64'(q1.size() + q2.size()), 64'd0);

    for (int i = 0; i < 7; i++) run_pass(vecs[i]);

    // Stalled tile with spurious data and an ignored start pulse.
    q1.delete();
    q2.delete();
    tile_ready_in = 1'b0;
    @(negedge clk);
    base_addr = 8'h30; num_rows = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!tile_valid_out && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_tile_valid", 64'(tile_valid_out), 64'd1);
    snap = tile_out;
    n1 = q1.size();
    for (int i = 0; i < 10; i++) begin
      spur_v2 = (i == 3);
      start   = (i == 5);
      base_addr = 8'h00; num_rows = 8'd6;
      @(negedge clk);
      spur_v2 = 1'b0;
      start   = 1'b0;
      chk($sformatf("stall%0d_valid", i), 64'(tile_valid_out), 64'd1);
      chk($sformatf("stall%0d_tile", i), 64'(tile_out == snap), 64'd1);
    end
    chk("stall_no_new_req", 64'(q1.size()), 64'(n1));
    tile_ready_in = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_done", 64'(done), 64'd1);
    chk("stall_req_total", 64'(q1.size()), 64'd2);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", 64'(busy), 64'd0);
    chk("ignored_start_noreq", 64'(q1.size()), 64'd2);
    snap = tile_out;
    spur_v2 = 1'b1;
    @(negedge clk);
    spur_v2 = 1'b0;
    @(negedge clk);
    chk("idle_spurious", 64'(tile_out == snap), 64'd1);

    // Reset in WAIT; the pending responses arrive after reset releases.
    q1.delete();
    q2.delete();
    @(negedge clk);
    base_addr = 8'h50; num_rows = 8'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    chk("late_data_pending", 64'(data_1_valid_in), 64'd1);
    reset = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    #1 reset = 1'b0;
    n1 = q1.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_zero_outputs($sformatf("post_reset%0d", i));
    end
    chk("post_reset_noreq", 64'(q1.size()), 64'(n1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
